// File: rtl/sd_pkg.sv
// Shared definitions for the SD DAT-line blocks: FSM states, result codes,
// status token values and the CRC16 polynomial.
package sd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_CRC,
    ST_END,
    ST_TURN,
    ST_SWAIT,
    ST_STAT,
    ST_BUSYW,
    ST_DONE
  } dat_tx_state_t;

  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_CRC      = 3'd1;
  localparam logic [2:0] ERR_WRITE    = 3'd2;
  localparam logic [2:0] ERR_STAT_TO  = 3'd3;
  localparam logic [2:0] ERR_BUSY_TO  = 3'd4;
  localparam logic [2:0] ERR_UNDERRUN = 3'd5;
  localparam logic [2:0] ERR_ZERO_LEN = 3'd6;
  localparam logic [2:0] ERR_END_BIT  = 3'd7;

  localparam logic [2:0] CRCST_OK  = 3'b010;
  localparam logic [2:0] CRCST_BAD = 3'b101;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  // In 1-bit mode only DAT0 carries information; DAT3..1 idle high.
  function automatic logic [3:0] lane_map(input logic mode4, input logic [3:0] bits);
    return mode4 ? bits : {3'b111, bits[0]};
  endfunction

endpackage

// File: rtl/sd_crc16_x4.sv
// Four parallel serial CRC16 lanes (x^16+x^12+x^5+1), one per DAT line,
// with a shift-out mode that presents each lane's CRC MSB first.
module sd_crc16_x4
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       shift,
  input  logic [3:0] bits,
  output logic [3:0] msb
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [15:0] crc;

    always_ff @(posedge clk) begin
      if (clr)
        crc <= '0;
      else if (shift)
        crc <= {crc[14:0], 1'b0};
      else if (en)
        crc <= {crc[14:0], 1'b0} ^ ((bits[l] ^ crc[15]) ? CRC16_POLY : 16'h0000);
    end

    assign msb[l] = crc[15];
  end

endmodule

// File: rtl/sd_dat_tx.sv
// Host-side SD DAT write transmitter: frames one block on DAT[3:0], then
// collects the card's CRC status token and waits out card busy.
module sd_dat_tx
  import sd_pkg::*;
#(
  parameter int BLEN_W  = 12,
  parameter int STAT_TO = 8,
  parameter int BUSY_TO = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bus4,
  input  logic [BLEN_W-1:0] blk_len,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [3:0]        dat_o,
  output logic              dat_oe,
  input  logic [3:0]        dat_i,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err,
  output logic [2:0]        crc_status
);

  localparam int TW = $clog2(BUSY_TO + 2);

  dat_tx_state_t     state, state_d;
  logic              mode4, mode4_d;
  logic [BLEN_W-1:0] rem, rem_d;
  logic [7:0]        sreg, sreg_d;
  logic [2:0]        bcnt, bcnt_d;
  logic [3:0]        ccnt, ccnt_d;
  logic [TW-1:0]     tcnt, tcnt_d;
  logic [3:0]        dat_o_d;
  logic              oe_d;
  logic [2:0]        err_d, cst_d;
  logic              last_bit;
  logic              crc_clr, crc_en, crc_shift;
  logic [3:0]        crc_bits, crc_msb;
  logic              unused_dat;

  assign unused_dat = ^dat_i[3:1];

  function automatic logic [3:0] first_bits(input logic m4, input logic [7:0] b);
    return m4 ? b[7:4] : {3'b111, b[7]};
  endfunction

  function automatic logic [7:0] rest_bits(input logic m4, input logic [7:0] b);
    return m4 ? {b[3:0], 4'h0} : {b[6:0], 1'b0};
  endfunction

  sd_crc16_x4 u_crc (
    .clk   (clk),
    .clr   (crc_clr),
    .en    (crc_en),
    .shift (crc_shift),
    .bits  (crc_bits),
    .msb   (crc_msb)
  );

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Every edge decides the bus value for the next cycle, so dat_o/dat_oe
  // come straight from flops and the CRC advances in step with them.
  always_comb begin
    state_d   = state;
    mode4_d   = mode4;
    rem_d     = rem;
    sreg_d    = sreg;
    bcnt_d    = bcnt;
    ccnt_d    = ccnt;
    tcnt_d    = tcnt;
    dat_o_d   = dat_o;
    oe_d      = dat_oe;
    err_d     = err;
    cst_d     = crc_status;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_shift = 1'b0;
    crc_bits  = 4'hF;
    din_ready = 1'b0;
    last_bit  = mode4 ? (bcnt == 3'd1) : (bcnt == 3'd7);

    unique case (state)
      ST_IDLE: begin
        oe_d    = 1'b0;
        dat_o_d = 4'hF;
        if (start) begin
          cst_d = 3'b000;
          if (blk_len == '0) begin
            state_d = ST_DONE;
            err_d   = ERR_ZERO_LEN;
          end else begin
            state_d = ST_START;
            err_d   = ERR_OK;
            mode4_d = bus4;
            rem_d   = blk_len;
            crc_clr = 1'b1;
            oe_d    = 1'b1;
            dat_o_d = bus4 ? 4'h0 : 4'hE;
          end
        end
      end
      ST_START: din_ready = 1'b1;
      ST_DATA: begin
        if (!last_bit) begin
          dat_o_d  = first_bits(mode4, sreg);
          sreg_d   = rest_bits(mode4, sreg);
          bcnt_d   = bcnt + 3'd1;
          crc_en   = 1'b1;
          crc_bits = first_bits(mode4, sreg);
        end else if (rem != '0) begin
          din_ready = 1'b1;
        end else begin
          state_d   = ST_CRC;
          ccnt_d    = 4'd0;
          crc_shift = 1'b1;
          dat_o_d   = lane_map(mode4, crc_msb);
        end
      end
      ST_CRC: begin
        if (ccnt == 4'd15) begin
          state_d = ST_END;
          dat_o_d = 4'hF;
        end else begin
          ccnt_d    = ccnt + 4'd1;
          crc_shift = 1'b1;
          dat_o_d   = lane_map(mode4, crc_msb);
        end
      end
      ST_END: begin
        state_d = ST_TURN;
        oe_d    = 1'b0;
        dat_o_d = 4'hF;
        tcnt_d  = '0;
      end
      ST_TURN: begin
        tcnt_d = tcnt + TW'(1);
        if (tcnt == TW'(1)) begin
          state_d = ST_SWAIT;
          tcnt_d  = '0;
        end
      end
      ST_SWAIT: begin
        tcnt_d = tcnt + TW'(1);
        if (!dat_i[0]) begin
          state_d = ST_STAT;
          tcnt_d  = '0;
        end else if (tcnt == TW'(STAT_TO - 1)) begin
          state_d = ST_DONE;
          err_d   = ERR_STAT_TO;
        end
      end
      ST_STAT: begin
        if (tcnt != TW'(3)) begin
          cst_d  = {crc_status[1:0], dat_i[0]};
          tcnt_d = tcnt + TW'(1);
        end else begin
          state_d = ST_BUSYW;
          tcnt_d  = '0;
          if (crc_status != CRCST_OK)
            err_d = (crc_status == CRCST_BAD) ? ERR_CRC : ERR_WRITE;
          else if (!dat_i[0])
            err_d = ERR_END_BIT;
        end
      end
      ST_BUSYW: begin
        tcnt_d = tcnt + TW'(1);
        if (dat_i[0]) begin
          state_d = ST_DONE;
        end else if (tcnt == TW'(BUSY_TO)) begin
          state_d = ST_DONE;
          if (err == ERR_OK) err_d = ERR_BUSY_TO;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Byte handshake shared by START and the last bit of each DATA byte.
    if (din_ready) begin
      if (!din_valid) begin
        state_d = ST_DONE;
        err_d   = ERR_UNDERRUN;
        oe_d    = 1'b0;
        dat_o_d = 4'hF;
      end else begin
        state_d  = ST_DATA;
        bcnt_d   = 3'd0;
        rem_d    = rem - BLEN_W'(1);
        sreg_d   = rest_bits(mode4, din);
        dat_o_d  = first_bits(mode4, din);
        crc_en   = 1'b1;
        crc_bits = first_bits(mode4, din);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dat_o      <= 4'hF;
      dat_oe     <= 1'b0;
      err        <= ERR_OK;
      crc_status <= 3'b000;
    end else begin
      state      <= state_d;
      dat_o      <= dat_o_d;
      dat_oe     <= oe_d;
      err        <= err_d;
      crc_status <= cst_d;
    end
  end

  always_ff @(posedge clk) begin
    mode4 <= mode4_d;
    rem   <= rem_d;
    sreg  <= sreg_d;
    bcnt  <= bcnt_d;
    ccnt  <= ccnt_d;
    tcnt  <= tcnt_d;
  end

endmodule

// File: doc/sd_dat_tx.md
# sd_dat_tx

Host-side SD DAT-line write transmitter. Accepts one block of bytes over a valid/ready stream and frames it on DAT[3:0] in 1-bit or 4-bit bus mode: start bit, data, per-line CRC16, end bit. It then releases the bus, captures the card's CRC status token and waits out card busy. Sits between the write data FIFO and the DAT pad drivers; the command/transfer controller above it starts one block at a time.

## Interface
- `BLEN_W`, 12: width of `blk_len` in bytes; the legal length range is 1..2^BLEN_W-1.
- `STAT_TO`, 8: number of cycles after the turnaround in which the status start bit must appear.
- `BUSY_TO`, 65535: maximum number of cycles DAT0 may be held low as busy.
- `clk` in 1: SD clock domain; one bus bit time per cycle.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to transmit a block; honoured in IDLE only.
- `bus4` in 1: bus mode; 1 = 4-bit, 0 = 1-bit. Latched at `start`.
- `blk_len` in BLEN_W: block length in bytes. Latched at `start`.
- `din` in 8: write data byte.
- `din_valid` in 1: `din` holds a valid byte.
- `din_ready` out 1: the block takes `din` at this clock edge when `din_valid` is also high.
- `dat_o` out 4: DAT output value.
- `dat_oe` out 1: DAT output enable for all four lines.
- `dat_i` in 4: sampled DAT pad input.
- `busy` out 1: high whenever the block is not in IDLE.
- `done` out 1: one-cycle pulse at the end of the transfer.
- `err` out 3: result code, valid while `done` is high and held until the next `start`.
  - 0 = OK
  - 1 = CRC rejected
  - 2 = write error
  - 3 = status timeout
  - 4 = busy timeout
  - 5 = data underrun
  - 6 = zero length
  - 7 = bad status end bit
- `crc_status` out 3: captured status bits, status bit 2 first on the wire.

## Operation
- **Reset values:** `dat_o`=4'hF, `dat_oe`=0, `din_ready`=0, `busy`=0, `done`=0, `err`=0, `crc_status`=0, state IDLE.
- **States:** IDLE → START → DATA → CRC → END → TURN → SWAIT → STAT → BUSYW → DONE → IDLE.
- **IDLE:** `dat_oe`=0. On `start`:
  - If `blk_len`=0: go to DONE with `err`=6. There is no bus activity.
  - Otherwise: latch `bus4` and `blk_len`, clear all CRCs, go to START.
- **START (1 cycle):** `dat_oe`=1 and every active line is driven 0.
  - `din_ready`=1 in this cycle to fetch byte 0.
  - Inactive lines (3:1 in 1-bit mode) are always driven 1 while `dat_oe`=1.
- **DATA, 1-bit mode:** 8 cycles per byte, MSB first, on `dat_o[0]`.
- **DATA, 4-bit mode:** 2 cycles per byte, high nibble first. `dat_o[3]` carries bit 7 and then bit 3.
- **Byte fetch:** `din_ready`=1 combinationally in the last bit cycle of every byte except the final byte. The accepted byte is output starting the next cycle, so there are no gap cycles.
- **Underrun:** `din_ready` & !`din_valid` at an edge means underrun. Next state is DONE with `err`=5, and `dat_oe` drops immediately.
- **CRC:** one CRC16 per active line.
  - Polynomial x^16+x^12+x^5+1, initial value 0.
  - Each line's CRC is updated with exactly the data bits that line carries.
- **CRC state (16 cycles):** each line outputs its CRC MSB first.
- **END (1 cycle):** active lines are driven 1.
- **TURN (2 cycles):** `dat_oe`=0.
- **SWAIT:** sample `dat_i[0]`. The first 0 seen starts STAT. If no 0 arrives within `STAT_TO` cycles, go to DONE with `err`=3.
- **STAT (4 cycles):**
  - Shift `dat_i[0]` into `crc_status` for 3 cycles.
  - The 4th cycle is the end bit, which must be 1; otherwise `err`=7.
  - Status 010 means accepted. 101 gives `err`=1. Any other value gives `err`=2.
  - Non-OK codes still proceed to BUSYW.
- **BUSYW:** wait while `dat_i[0]`=0. The first 1 goes to DONE. If more than `BUSY_TO` cycles pass, go to DONE with `err`=4.
  - When several errors occur, the first error recorded wins.
- **DONE (1 cycle):** `done`=1, then IDLE.
- **`start` outside IDLE** is ignored.
- **`rst` mid-transfer:** the next cycle is IDLE with reset values. There is no partial end bit.

## Timing
- `start` at cycle 0 puts the start bit on the bus in cycle 1.
- 1-bit mode: data occupies cycles 2..8N+1, CRC 8N+2..8N+17, end bit 8N+18.
- 4-bit mode: data occupies cycles 2..2N+1, CRC 2N+2..2N+17, end bit 2N+18.
- `dat_o`/`dat_oe` are registered, with no combinational path from `dat_i` to outputs.
- `din_ready` is combinational from state only, never from `din_valid`.
- `busy` falls in the cycle after `done`.
- Minimum turnaround from `done` to the next accepted `start` is 1 cycle.

## Structure
- Shared package `sd_pkg`:
  - state enum `dat_tx_state_t`
  - `err` code constants
  - status token constants `CRCST_OK`=3'b010 and `CRCST_BAD`=3'b101
  - CRC16 polynomial constant
- One sub-module, `sd_crc16_x4`: four parallel CRC16 lanes with per-lane bit inputs, a common enable, a shift-out mode (one bit per lane per cycle) and a clear.
- Bit, byte and timeout counters live in `sd_dat_tx`.

## Test plan
- **1-bit, 512 bytes of 0x00, card status 010 and 3 busy cycles:**
  - `dat_o[0]` shows 0, then 4096 zeros, then CRC 0x0000, then 1.
  - `done` with `err`=0.
  - `din_ready` count = 512.
- **4-bit, 8 bytes 0x01..0x08:**
  - Nibble sequence 0,1,0,2,…,0,8 on `dat_o`.
  - The four lane CRCs match a golden model.
  - The end bit lands at cycle 34.
- **Status 101** → `err`=1, `crc_status`=5. **No status start bit for 8 cycles** → `err`=3.
- **`din_valid` dropped at byte 3** → `dat_oe`=0 in the next cycle, `done` with `err`=5.
- **`blk_len`=0** → `done` in the next cycle with `err`=6 and `dat_oe` never asserted. **`rst` pulsed mid-CRC** → IDLE next cycle with all reset values.
